uart_rx_ctrl: RTL

Controller between the UART receiver and the TinyBF core's input (',') instruction path. It buffers received bytes in a small FIFO and serves blocking CPU read requests through a req/ack handshake. It also tracks overflow and framing errors for status readout. It sits between the receiver's rx_data/rx_valid/rx_frame_err pulse outputs and the core's input-request logic.

---
 rtl/uart_rx_ctrl_pkg.sv | 17 +
 rtl/uart_rx_ctrl_if.sv | 30 +++
 rtl/uart_rx_fifo.sv | 55 +++++
 rtl/uart_rx_ctrl.sv | 121 ++++++++++++
 4 files changed

// File: rtl/uart_rx_ctrl_pkg.sv
// Shared types and constants for the UART receive controller and its FIFO.
package uart_rx_ctrl_pkg;

    localparam int unsigned RX_FIFO_DEPTH = 4;
    localparam int unsigned RX_FIFO_ADDR_W = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        ACK       = 2'd2
    } rd_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Receiver-side pulses, CPU read handshake and status readout of the RX controller.
interface uart_rx_ctrl_if #(
    parameter int unsigned ADDR_W = 2
);
    logic [7:0]      rx_data_i;
    logic            rx_valid_i;
    logic            rx_frame_err_i;
    logic            clr_i;
    logic            rd_req_i;
    logic [7:0]      rd_data_o;
    logic            rd_ack_o;
    logic            rd_wait_o;
    logic [ADDR_W:0] fifo_level_o;
    logic            fifo_empty_o;
    logic            fifo_full_o;
    logic            ovf_o;
    logic [7:0]      frame_err_cnt_o;

    modport master (
        output rx_data_i, rx_valid_i, rx_frame_err_i, clr_i, rd_req_i,
        input  rd_data_o, rd_ack_o, rd_wait_o, fifo_level_o, fifo_empty_o,
               fifo_full_o, ovf_o, frame_err_cnt_o
    );

    modport slave (
        input  rx_data_i, rx_valid_i, rx_frame_err_i, clr_i, rd_req_i,
        output rd_data_o, rd_ack_o, rd_wait_o, fifo_level_o, fifo_empty_o,
               fifo_full_o, ovf_o, frame_err_cnt_o
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Byte FIFO with separate level register so full/empty never alias; flush wins over push/pop.
module uart_rx_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [7:0]        din,
    output logic [7:0]        dout,
    output logic [ADDR_W:0]   level,
    output logic              full,
    output logic              empty
);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign empty   = (level == '0);
    assign full    = (level == (ADDR_W+1)'(DEPTH));
    assign dout    = mem[rd_ptr];
    // a pop in the same cycle frees the slot a full-FIFO push needs
    assign push_ok = push && (!full || pop) && !flush;
    assign pop_ok  = pop && !empty && !flush;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   level <= level + (ADDR_W+1)'(1);
                2'b01:   level <= level - (ADDR_W+1)'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Buffers UART bytes and serves blocking CPU reads via req/ack; tracks overflow and framing errors.
module uart_rx_ctrl
    import uart_rx_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH  = RX_FIFO_DEPTH,
    parameter int unsigned ADDR_W = RX_FIFO_ADDR_W
) (
    input  logic          clk_i,
    input  logic          rst_i,
    uart_rx_ctrl_if.slave bus
);

    rd_state_e       state_q, state_d;
    logic [7:0]      rd_data_q, rd_data_d;
    logic            ack_q, ack_d;
    logic            wait_q, wait_d;
    logic            ovf_q;
    logic [7:0]      err_cnt_q;
    logic            pop;
    logic [7:0]      head;
    logic [ADDR_W:0] level;
    logic            full;
    logic            empty;

    uart_rx_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .flush (bus.clr_i),
        .push  (bus.rx_valid_i),
        .pop   (pop),
        .din   (bus.rx_data_i),
        .dout  (head),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            rd_data_q <= '0;
            ack_q     <= 1'b0;
            wait_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_data_q <= rd_data_d;
            ack_q     <= ack_d;
            wait_q    <= wait_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_data_d = rd_data_q;
        ack_d     = 1'b0;
        wait_d    = 1'b0;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.rd_req_i) begin
                    if (!empty) begin
                        pop       = 1'b1;
                        rd_data_d = head;
                        ack_d     = 1'b1;
                        state_d   = ACK;
                    end else begin
                        wait_d  = 1'b1;
                        state_d = WAIT_DATA;
                    end
                end
            end
            WAIT_DATA: begin
                if (!bus.rd_req_i) begin
                    state_d = IDLE;
                end else if (!empty) begin
                    pop       = 1'b1;
                    rd_data_d = head;
                    ack_d     = 1'b1;
                    state_d   = ACK;
                end else begin
                    wait_d = 1'b1;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.clr_i) begin
            state_d   = IDLE;
            rd_data_d = rd_data_q;
            ack_d     = 1'b0;
            wait_d    = 1'b0;
            pop       = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ovf_q     <= 1'b0;
            err_cnt_q <= '0;
        end else if (bus.clr_i) begin
            ovf_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            if (bus.rx_valid_i && full && !pop) ovf_q <= 1'b1;
            if (bus.rx_frame_err_i) err_cnt_q <= sat_inc8(err_cnt_q);
        end
    end

    assign bus.rd_data_o       = rd_data_q;
    assign bus.rd_ack_o        = ack_q;
    assign bus.rd_wait_o       = wait_q;
    assign bus.fifo_level_o    = level;
    assign bus.fifo_empty_o    = empty;
    assign bus.fifo_full_o     = full;
    assign bus.ovf_o           = ovf_q;
    assign bus.frame_err_cnt_o = err_cnt_q;

endmodule
